// File: rtl/gl_pkg.sv
// Shared constants and types for the GL triangle rasterizer.
// Float32 field layout, vertex slice offsets and the scan FSM state encoding.
package gl_pkg;

   localparam int FLT_BIAS   = 127;
   localparam int FLT_MANT_W = 23;

   localparam int X_HI = 95;
   localparam int Y_HI = 63;
   localparam int Z_HI = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      SETUP = 2'd2,
      SCAN  = 2'd3
   } state_t;

endpackage

// File: rtl/gl_f2i.sv
// Combinational float32 to unsigned integer conversion, truncating toward zero.
// Negative or sub-unity inputs give 0; oversized, Inf and positive NaN inputs saturate.
module gl_f2i
   import gl_pkg::*;
#(
   parameter int COORD_W = 16
) (
   input  logic [31:0]        f,
   output logic [COORD_W-1:0] i
);

   localparam logic [7:0] BIAS_E = 8'(FLT_BIAS);
   localparam logic [7:0] MAX_E  = 8'(FLT_BIAS + COORD_W - 1);
   localparam logic [7:0] MANT_E = 8'(FLT_MANT_W);

   logic [7:0]          exp_s;
   logic [7:0]          shift_s;
   logic [FLT_MANT_W:0] sig_s;

   // Decode the float and pick zero, saturation or the shifted significand.
   always_comb begin
      exp_s   = f[30:23];
      sig_s   = {1'b1, f[FLT_MANT_W-1:0]};
      shift_s = MANT_E - (exp_s - BIAS_E);
      if (f[31]) begin
         i = {COORD_W{1'b0}};
      end else if (exp_s < BIAS_E) begin
         i = {COORD_W{1'b0}};
      end else if (exp_s > MAX_E) begin
         i = {COORD_W{1'b1}};
      end else begin
         i = COORD_W'(sig_s >> shift_s);
      end
   end

endmodule

// File: rtl/gl_rasterizer.sv
// Triangle scan converter: converts three float vertices to pixel space and walks
// the bounding box one pixel per clock, flagging pixels inside the triangle.
module gl_rasterizer
   import gl_pkg::*;
#(
   parameter int COORD_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fifo_ready,
   input  logic [95:0] fifo_in1,
   input  logic [95:0] fifo_in2,
   input  logic [95:0] fifo_in3,
   output logic [31:0] count_x,
   output logic [31:0] count_y,
   output logic        true,
   output logic        pix_valid,
   output logic        raster_ready
);

   localparam int CW = COORD_W;
   localparam int DW = COORD_W + 1;
   localparam int EW = 2 * COORD_W + 3;

   state_t                state_r, state_s;
   logic [31:0]           fx_r [3];
   logic [31:0]           fy_r [3];
   logic [CW-1:0]         ix_s [3];
   logic [CW-1:0]         iy_s [3];
   logic [CW-1:0]         vx_r [3];
   logic [CW-1:0]         vy_r [3];
   logic signed [DW-1:0]  dx_s [3];
   logic signed [DW-1:0]  dy_s [3];
   logic signed [DW-1:0]  dx_r [3];
   logic signed [DW-1:0]  dy_r [3];
   logic signed [EW-1:0]  e_s  [3];
   logic signed [EW-1:0]  area_s;
   logic [CW-1:0]         minx_s, maxx_s, miny_s, maxy_s;
   logic [CW-1:0]         minx_r, maxx_r, maxy_r;
   logic [CW-1:0]         px_r, py_r;
   logic                  area_nz_r;
   logic                  inside_s;
   logic                  last_s;

   function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // E = d_x*(py-ya) - d_y*(px-xa), wide enough that no product can overflow.
   function automatic logic signed [EW-1:0] edge_fn(
      input logic signed [DW-1:0] ddx, ddy,
      input logic [CW-1:0]        xa, ya, px, py
   );
      logic signed [EW-1:0] sdx, sdy, rel_x, rel_y;
      sdx   = {{(EW-DW){ddx[DW-1]}}, ddx};
      sdy   = {{(EW-DW){ddy[DW-1]}}, ddy};
      rel_x = $signed({{(EW-CW){1'b0}}, px}) - $signed({{(EW-CW){1'b0}}, xa});
      rel_y = $signed({{(EW-CW){1'b0}}, py}) - $signed({{(EW-CW){1'b0}}, ya});
      return sdx * rel_y - sdy * rel_x;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_conv
      gl_f2i #(.COORD_W(COORD_W)) u_fx (.f(fx_r[g]), .i(ix_s[g]));
      gl_f2i #(.COORD_W(COORD_W)) u_fy (.f(fy_r[g]), .i(iy_s[g]));
   end

   // Triangle setup: bounding box, edge deltas and doubled signed area.
   always_comb begin
      minx_s = min3(vx_r[0], vx_r[1], vx_r[2]);
      maxx_s = max3(vx_r[0], vx_r[1], vx_r[2]);
      miny_s = min3(vy_r[0], vy_r[1], vy_r[2]);
      maxy_s = max3(vy_r[0], vy_r[1], vy_r[2]);
      for (int k = 0; k < 3; k++) begin
         dx_s[k] = $signed({1'b0, vx_r[(k + 1) % 3]}) - $signed({1'b0, vx_r[k]});
         dy_s[k] = $signed({1'b0, vy_r[(k + 1) % 3]}) - $signed({1'b0, vy_r[k]});
      end
      area_s = edge_fn(dx_s[0], dy_s[0], vx_r[0], vy_r[0], vx_r[2], vy_r[2]);
   end

   // Per-pixel coverage; both windings accepted, edge pixels count as inside.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         e_s[k] = edge_fn(dx_r[k], dy_r[k], vx_r[k], vy_r[k], px_r, py_r);
      end
      if (area_nz_r) begin
         inside_s = ((e_s[0] >= 0) && (e_s[1] >= 0) && (e_s[2] >= 0)) ||
                    ((e_s[0] <= 0) && (e_s[1] <= 0) && (e_s[2] <= 0));
      end else begin
         inside_s = 1'b0;
      end
      last_s = (px_r == maxx_r) && (py_r == maxy_r);
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = fifo_ready ? CONV : IDLE;
         CONV:    state_s = SETUP;
         SETUP:   state_s = SCAN;
         SCAN:    state_s = last_s ? IDLE : SCAN;
         default: state_s = IDLE;
      endcase
   end

   // Datapath registers: capture, conversion, setup and raster-order walk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            fx_r[k] <= 32'd0;
            fy_r[k] <= 32'd0;
            vx_r[k] <= {CW{1'b0}};
            vy_r[k] <= {CW{1'b0}};
            dx_r[k] <= {DW{1'b0}};
            dy_r[k] <= {DW{1'b0}};
         end
         minx_r    <= {CW{1'b0}};
         maxx_r    <= {CW{1'b0}};
         maxy_r    <= {CW{1'b0}};
         px_r      <= {CW{1'b0}};
         py_r      <= {CW{1'b0}};
         area_nz_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (fifo_ready) begin
                  fx_r[0] <= fifo_in1[X_HI -: 32];
                  fy_r[0] <= fifo_in1[Y_HI -: 32];
                  fx_r[1] <= fifo_in2[X_HI -: 32];
                  fy_r[1] <= fifo_in2[Y_HI -: 32];
                  fx_r[2] <= fifo_in3[X_HI -: 32];
                  fy_r[2] <= fifo_in3[Y_HI -: 32];
               end
            end
            CONV: begin
               for (int k = 0; k < 3; k++) begin
                  vx_r[k] <= ix_s[k];
                  vy_r[k] <= iy_s[k];
               end
            end
            SETUP: begin
               for (int k = 0; k < 3; k++) begin
                  dx_r[k] <= dx_s[k];
                  dy_r[k] <= dy_s[k];
               end
               minx_r    <= minx_s;
               maxx_r    <= maxx_s;
               maxy_r    <= maxy_s;
               px_r      <= minx_s;
               py_r      <= miny_s;
               area_nz_r <= (area_s != {EW{1'b0}});
            end
            SCAN: begin
               if (px_r == maxx_r) begin
                  px_r <= minx_r;
                  py_r <= py_r + CW'(1);
               end else begin
                  px_r <= px_r + CW'(1);
               end
            end
            default: begin
               px_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // State register and registered pixel outputs; pixel fields hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         count_x      <= 32'd0;
         count_y      <= 32'd0;
         true         <= 1'b0;
         pix_valid    <= 1'b0;
         raster_ready <= 1'b1;
      end else begin
         state_r      <= state_s;
         raster_ready <= (state_s == IDLE);
         pix_valid    <= (state_r == SCAN);
         if (state_r == SCAN) begin
            count_x <= 32'(px_r);
            count_y <= 32'(py_r);
            true    <= inside_s;
         end
      end
   end

endmodule

// File: tb/tb_gl_rasterizer.sv
// Scoreboard bench for gl_rasterizer: expected pixels are queued when a triangle
// is issued and popped as the DUT presents them.
module tb_gl_rasterizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_ready;
   logic [95:0] fifo_in1, fifo_in2, fifo_in3;
   logic [31:0] count_x, count_y;
   logic        true_o;
   logic        pix_valid;
   logic        raster_ready;

   typedef struct {
      int x;
      int y;
      bit t;
   } pix_t;

   pix_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   obs_true [0:15][0:15];

   gl_rasterizer #(.COORD_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_ready   (fifo_ready),
      .fifo_in1     (fifo_in1),
      .fifo_in2     (fifo_in2),
      .fifo_in3     (fifo_in3),
      .count_x      (count_x),
      .count_y      (count_y),
      .true         (true_o),
      .pix_valid    (pix_valid),
      .raster_ready (raster_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic bit model_inside(int ax, int ay, int bx, int by, int cx, int cy,
                                       int px, int py);
      longint e0, e1, e2, area;
      e0   = longint'(bx - ax) * (py - ay) - longint'(by - ay) * (px - ax);
      e1   = longint'(cx - bx) * (py - by) - longint'(cy - by) * (px - bx);
      e2   = longint'(ax - cx) * (py - cy) - longint'(ay - cy) * (px - cx);
      area = longint'(bx - ax) * (cy - ay) - longint'(by - ay) * (cx - ax);
      return (area != 0) && ((e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                             (e0 <= 0 && e1 <= 0 && e2 <= 0));
   endfunction

   task automatic push_expected(int ax, int ay, int bx, int by, int cx, int cy);
      int   mnx, mxx, mny, mxy;
      pix_t p;
      mnx = ax; if (bx < mnx) mnx = bx; if (cx < mnx) mnx = cx;
      mxx = ax; if (bx > mxx) mxx = bx; if (cx > mxx) mxx = cx;
      mny = ay; if (by < mny) mny = by; if (cy < mny) mny = cy;
      mxy = ay; if (by > mxy) mxy = by; if (cy > mxy) mxy = cy;
      for (int y = mny; y <= mxy; y++) begin
         for (int x = mnx; x <= mxx; x++) begin
            p.x = x;
            p.y = y;
            p.t = model_inside(ax, ay, bx, by, cx, cy, x, y);
            sb.push_back(p);
         end
      end
   endtask

   task automatic run_tri(input string name,
                          input logic [31:0] fx0, fy0, fx1, fy1, fx2, fy2,
                          input int x0, y0, x1, y1, x2, y2,
                          input int n_pix, n_in, abort_after);
      int   lat, npix, nin;
      pix_t e;
      for (int w = 0; w < 20 && !raster_ready; w++) @(negedge clk);
      check({name, ":ready_wait"}, raster_ready, 1);
      sb.delete();
      push_expected(x0, y0, x1, y1, x2, y2);
      fifo_in1   = {fx0, fy0, 32'h0000_0000};
      fifo_in2   = {fx1, fy1, 32'h3F80_0000};
      fifo_in3   = {fx2, fy2, 32'h0000_0000};
      fifo_ready = 1'b1;
      @(negedge clk);
      fifo_ready = 1'b0;
      check({name, ":busy"}, raster_ready, 0);
      lat = 0;
      while (!pix_valid && lat < 10) begin
         lat++;
         @(negedge clk);
      end
      check({name, ":latency"}, lat, 3);
      npix = 0;
      nin  = 0;
      e    = '{x: 0, y: 0, t: 1'b0};
      while (pix_valid && npix < 2000) begin
         if (sb.size() == 0) begin
            check({name, ":extra_pixel"}, 1, 0);
            break;
         end
         e = sb.pop_front();
         check({name, ":x"}, count_x, e.x);
         check({name, ":y"}, count_y, e.y);
         check({name, ":true"}, true_o, e.t);
         if (true_o) nin++;
         if (count_x < 16 && count_y < 16) obs_true[count_x][count_y] = true_o;
         npix++;
         if (sb.size() != 0) check({name, ":busy_scan"}, raster_ready, 0);
         if (abort_after != 0 && npix == abort_after) begin
            #2 rst_n = 1'b0;
            #1;
            check({name, ":rst_valid"}, pix_valid, 0);
            check({name, ":rst_ready"}, raster_ready, 1);
            check({name, ":rst_x"}, count_x, 0);
            check({name, ":rst_y"}, count_y, 0);
            check({name, ":rst_true"}, true_o, 0);
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
      end
      check({name, ":pixels"}, npix, n_pix);
      check({name, ":inside"}, nin, n_in);
      check({name, ":left_over"}, sb.size(), 0);
      check({name, ":end_valid"}, pix_valid, 0);
      check({name, ":end_ready"}, raster_ready, 1);
      check({name, ":hold_x"}, count_x, e.x);
      check({name, ":hold_y"}, count_y, e.y);
   endtask

   initial begin
      rst_n      = 1'b0;
      fifo_ready = 1'b0;
      fifo_in1   = 96'd0;
      fifo_in2   = 96'd0;
      fifo_in3   = 96'd0;
      repeat (3) @(negedge clk);
      check("reset:ready", raster_ready, 1);
      check("reset:valid", pix_valid, 0);
      check("reset:x", count_x, 0);
      check("reset:y", count_y, 0);
      check("reset:true", true_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_tri("base", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4120_0000,
              32'h4120_0000, 32'h3F80_0000, 1, 1, 1, 10, 10, 1, 100, 55, 0);
      check("base:in(1,1)", obs_true[1][1], 1);
      check("base:in(5,6)", obs_true[5][6], 1);
      check("base:in(6,6)", obs_true[6][6], 0);
      check("base:in(10,10)", obs_true[10][10], 0);

      run_tri("reverse", 32'h3F80_0000, 32'h3F80_0000, 32'h4120_0000, 32'h3F80_0000,
              32'h3F80_0000, 32'h4120_0000, 1, 1, 10, 1, 1, 10, 100, 55, 0);
      check("reverse:in(5,6)", obs_true[5][6], 1);
      check("reverse:in(6,6)", obs_true[6][6], 0);

      run_tri("conv", 32'hC000_0000, 32'h0000_0000, 32'h4030_0000, 32'h0000_0000,
              32'h3F00_0000, 32'h4000_0000, 0, 0, 2, 0, 0, 2, 9, 6, 0);

      run_tri("sat", 32'h4E6E_6B28, 32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000,
              32'h4780_0000, 32'h4040_0000, 65535, 1, 65535, 2, 65535, 3, 3, 0, 0);

      run_tri("collinear", 32'h0000_0000, 32'h0000_0000, 32'h4080_0000, 32'h4080_0000,
              32'h4100_0000, 32'h4100_0000, 0, 0, 4, 4, 8, 8, 81, 0, 0);

      run_tri("point", 32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000,
              32'h4040_0000, 32'h4040_0000, 3, 3, 3, 3, 3, 3, 1, 0, 0);

      run_tri("abort", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4120_0000,
              32'h4120_0000, 32'h3F80_0000, 1, 1, 1, 10, 10, 1, 0, 0, 20);

      run_tri("after_rst", 32'hC000_0000, 32'h0000_0000, 32'h4030_0000, 32'h0000_0000,
              32'h3F00_0000, 32'h4000_0000, 0, 0, 2, 0, 0, 2, 9, 6, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gl_rasterizer.md
Name: gl_rasterizer

Overview:
- Triangle scan-converter for the GL pipeline; sits between the vertex/geometry FIFO and the fragment stage.
- Accepts three vertices as IEEE-754 single-precision (x,y,z).
- Converts x,y to integer pixel coordinates and walks the triangle's bounding box one pixel per clock.
- For each pixel, emits its coordinates and an inside/outside flag.

Parameters:
- COORD_W, 16, integer pixel-coordinate width; converted coordinates saturate to 2^COORD_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous release.
- fifo_ready  in  1  vertex FIFO has a triangle on fifo_in1..3.
- fifo_in1  in  96  vertex 0: [95:64]=x, [63:32]=y, [31:0]=z; float32.
- fifo_in2  in  96  vertex 1, same packing.
- fifo_in3  in  96  vertex 2, same packing.
- count_x  out  32  current pixel x, unsigned integer, zero-extended.
- count_y  out  32  current pixel y, unsigned integer, zero-extended.
- true  out  1  current pixel lies inside the triangle.
- pix_valid  out  1  count_x, count_y and true are valid this cycle.
- raster_ready  out  1  block is idle and will accept a triangle.

Behaviour:
- Reset: FSM goes to IDLE. count_x=0, count_y=0, true=0, pix_valid=0, raster_ready=1. Reset asserted mid-scan aborts the triangle immediately.
- FSM states: IDLE, CONV, SETUP, SCAN.
- IDLE:
  - raster_ready=1.
  - On a rising edge with fifo_ready=1, capture fifo_in1..3 and go to CONV.
  - fifo_ready is ignored in all other states; z is ignored.
- CONV (1 cycle): float-to-int conversion of all six x/y values, registered.
  - Conversion truncates toward zero.
  - Sign=1 or unbiased exponent <0 -> 0.
  - Exponent > COORD_W-1, Inf or NaN (positive sign) -> 2^COORD_W-1.
  - Otherwise the value is {1,mantissa} shifted right by (23-exp).
- SETUP (1 cycle):
  - Bounding box minx/maxx/miny/maxy = min/max of the integer vertices.
  - Edge deltas dx_i = x_{i+1}-x_i and dy_i = y_{i+1}-y_i (indices mod 3), each COORD_W+1-bit signed.
  - Twice the signed area = E0 evaluated at v2.
- SCAN:
  - One pixel per cycle in raster order: x from minx to maxx (inner loop), then y from miny to maxy (outer loop).
  - Sample point is the integer pixel coordinate, with no +0.5 offset.
  - Edge function: E_i = dx_i*(py-y_i) - dy_i*(px-x_i), evaluated at ≥2*COORD_W+3-bit signed width.
  - true=1 iff area≠0 and (all E_i≥0 or all E_i≤0). Both windings are accepted and edge pixels count as inside.
  - Zero-area triangles are still scanned, with true=0 for every pixel.
- Outputs are registered.
  - With fifo_ready sampled at edge k, the first pixel is presented (pix_valid=1) after edge k+3.
  - One pixel is presented per clock thereafter.
  - Total pixels = (maxx-minx+1)*(maxy-miny+1); a single-point box yields exactly 1 pixel.
- After the last pixel (x=maxx, y=maxy), the next state is IDLE: pix_valid=0, raster_ready=1. count_x, count_y and true hold their last values.
- raster_ready=0 in CONV, SETUP and SCAN.
- Back-to-back triangles: the earliest accept is the edge after raster_ready returns to 1.

Decomposition:
- Shared package gl_pkg holds:
  - FLT_BIAS=127, FLT_MANT_W=23.
  - Vertex field slice offsets (X_HI=95, Y_HI=63, Z_HI=31).
  - The FSM state enum.
- One natural sub-module: gl_f2i, a combinational float32-to-unsigned-int converter with saturation, instantiated six times.

Test Plan:
- Reset: hold rst_n=0 -> raster_ready=1, pix_valid=0, count_x=count_y=0, true=0.
- Base triangle: vertices (1,1,0), (1,10,0), (10,1,0), i.e. 0x3F800000 / 0x41200000, fifo_ready=1 -> raster_ready=0; pixel values as follows:
  - Exactly 100 pix_valid cycles, first at (1,1), last at (10,10).
  - 55 pixels with true=1 (x+y≤11).
  - (1,1)=1, (5,6)=1, (6,6)=0, (10,10)=0.
  - raster_ready=1 after the last pixel.
- Reverse winding: same vertices with fifo_in2 and fifo_in3 swapped -> identical 55-pixel inside set.
- Conversion edges:
  - Vertex x=-2.0 (0xC0000000) -> treated as 0.
  - x=2.75 (0x40300000) -> 2.
  - x=1e9 -> 65535.
  - Check bounding-box corners through count_x.
- Degenerate: collinear (0,0), (4,4), (8,8) -> 81 pixels, all true=0. Single point, all vertices (3,3) -> 1 pixel (3,3), true=0.
- Reset mid-scan: deassert rst_n during SCAN -> outputs zero asynchronously. After release, a new triangle is accepted and scanned from its first pixel.
